// File: rtl/io_sw_debounce.sv
// io_sw_debounce
//   Conditions the raw board switch bank into a clean, clock-synchronous,
//   debounced word for the core, plus per-bit edge pulses and a change flag.
//
//   Each bit is synchronised through two flops. A free-running prescaler
//   produces a sample tick every TICK_DIV cycles. On each tick, a per-bit
//   counter tracks how many consecutive ticks the synchronised level has
//   differed from the accepted level. A new level is accepted after
//   STABLE_SAMPLES such ticks.
//
// Ports
//   i_clk      system clock
//   i_reset    asynchronous, active-high reset
//   i_sw_raw   raw switch levels, asynchronous to i_clk
//   o_io_sw    debounced switch word
//   o_sw_rise  one-cycle pulse per bit on an accepted 0->1 change
//   o_sw_fall  one-cycle pulse per bit on an accepted 1->0 change
//   o_changed  one-cycle pulse, OR of all rise/fall bits
//   o_tick     registered sample-tick strobe
module io_sw_debounce #(
  parameter int          WIDTH          = 32,
  parameter int          TICK_DIV       = 1000,
  parameter int          STABLE_SAMPLES = 4,
  parameter logic [31:0] RESET_VAL      = 32'h0
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_sw_raw,
  output logic [WIDTH-1:0] o_io_sw,
  output logic [WIDTH-1:0] o_sw_rise,
  output logic [WIDTH-1:0] o_sw_fall,
  output logic             o_changed,
  output logic             o_tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [WIDTH-1:0] RST_WORD  = WIDTH'(RESET_VAL);
  localparam logic [PW-1:0]    PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0]    CNT_LAST  = CW'(STABLE_SAMPLES - 1);

  logic [WIDTH-1:0]         sync1;
  logic [WIDTH-1:0]         sync2;
  logic [PW-1:0]            pre;
  logic                     tick_cond;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_nxt;
  logic [WIDTH-1:0]         sw_nxt;
  logic [WIDTH-1:0]         rise_nxt;
  logic [WIDTH-1:0]         fall_nxt;
  logic                     changed_nxt;

  // With TICK_DIV=1 the prescaler is stuck at 0 and every cycle is a tick.
  assign tick_cond = (pre == PRE_LAST);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1 <= RST_WORD;
      sync2 <= RST_WORD;
    end else begin
      sync1 <= i_sw_raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pre    <= '0;
      o_tick <= 1'b0;
    end else begin
      pre    <= tick_cond ? '0 : pre + 1'b1;
      o_tick <= tick_cond;
    end
  end

  // Any tick that sees the accepted level again clears the count, so a
  // bounce gives no partial credit toward acceptance.
  always_comb begin
    cnt_nxt  = cnt;
    sw_nxt   = o_io_sw;
    rise_nxt = '0;
    fall_nxt = '0;
    if (tick_cond) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == o_io_sw[i]) begin
          cnt_nxt[i] = '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt_nxt[i]  = '0;
          sw_nxt[i]   = sync2[i];
          rise_nxt[i] = sync2[i];
          fall_nxt[i] = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
    changed_nxt = (|rise_nxt) | (|fall_nxt);
  end

  // Pulses are registered alongside o_io_sw so they appear in the same
  // cycle the new level becomes visible.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt       <= '0;
      o_io_sw   <= RST_WORD;
      o_sw_rise <= '0;
      o_sw_fall <= '0;
      o_changed <= 1'b0;
    end else begin
      cnt       <= cnt_nxt;
      o_io_sw   <= sw_nxt;
      o_sw_rise <= rise_nxt;
      o_sw_fall <= fall_nxt;
      o_changed <= changed_nxt;
    end
  end

endmodule

// File: tb/tb_io_sw_debounce.sv
module tb_io_sw_debounce;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] raw_a = '0;
  logic [31:0] raw_b = '0;
  logic [31:0] sw_a, rise_a, fall_a, sw_b, rise_b, fall_b;
  logic        chg_a, tick_a, chg_b, tick_b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Fast instance: sample every cycle, non-zero reset word.
  io_sw_debounce #(.WIDTH(32), .TICK_DIV(1), .STABLE_SAMPLES(4), .RESET_VAL(32'h0000_00A5)) dut_a (
    .i_clk(clk), .i_reset(rst), .i_sw_raw(raw_a), .o_io_sw(sw_a),
    .o_sw_rise(rise_a), .o_sw_fall(fall_a), .o_changed(chg_a), .o_tick(tick_a));

  // Prescaled instance: sample every 4 cycles.
  io_sw_debounce #(.WIDTH(32), .TICK_DIV(4), .STABLE_SAMPLES(4), .RESET_VAL(32'h0)) dut_b (
    .i_clk(clk), .i_reset(rst), .i_sw_raw(raw_b), .o_io_sw(sw_b),
    .o_sw_rise(rise_b), .o_sw_fall(fall_b), .o_changed(chg_b), .o_tick(tick_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [8:0] pat;
    int n, found, lat;

    // ---------------- reset state ----------------
    repeat (3) step();
    chk("rst_sw_a", sw_a, 32'h0000_00A5);
    chk("rst_pulses_a", rise_a | fall_a, 32'h0);
    chk("rst_chg_tick_a", {30'h0, chg_a, tick_a}, 32'h0);
    chk("rst_sw_b", sw_b, 32'h0);

    // ---------------- release with raw=0: A5 held, then falls ----------------
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("rel_hold_sw", sw_a, 32'h0000_00A5);
      chk("rel_no_pulse", {31'h0, chg_a} | rise_a | fall_a, 32'h0);
    end
    chk("rel_tick_a", {31'h0, tick_a}, 32'h1);
    step();
    chk("rel_fall_sw", sw_a, 32'h0);
    chk("rel_fall_pulse", fall_a, 32'h0000_00A5);
    chk("rel_fall_chg", {31'h0, chg_a}, 32'h1);
    step();
    chk("rel_fall_clear", {31'h0, chg_a} | fall_a, 32'h0);

    // ---------------- clean step on bit3, TICK_DIV=1 ----------------
    @(negedge clk);
    raw_a = 32'h8;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("step_hold", sw_a, 32'h0);
      chk("step_no_chg", {31'h0, chg_a}, 32'h0);
    end
    step();
    chk("step6_sw", sw_a, 32'h8);
    chk("step6_rise", rise_a, 32'h8);
    chk("step6_chg", {31'h0, chg_a}, 32'h1);
    step();
    chk("step7_clear", {31'h0, chg_a} | rise_a | fall_a, 32'h0);
    chk("step7_sw", sw_a, 32'h8);

    // ---------------- bounce on bit0: 1,0,1,1,0,1,1,1,1 ----------------
    pat = 9'b111101101;
    n = 0;
    for (int e = 1; e <= 20; e++) begin
      @(negedge clk);
      if (e <= 9) raw_a[0] = pat[e-1];
      step();
      if (rise_a[0]) n++;
      if (e == 10) chk("bounce_e10_sw", sw_a, 32'h8);
      if (e == 11) chk("bounce_e11_sw", sw_a, 32'h9);
    end
    chk("bounce_rise_count", n, 1);

    // ---------------- bit2 high, then multi-bit change ----------------
    @(negedge clk);
    raw_a = 32'hD;
    repeat (8) step();
    chk("pre_multi_sw", sw_a, 32'hD);
    @(negedge clk);
    raw_a = 32'h8000_000B;
    n = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (chg_a) n++;
      if (e == 5) chk("multi_e5_sw", sw_a, 32'hD);
      if (e == 6) begin
        chk("multi_rise", rise_a, 32'h8000_0002);
        chk("multi_fall", fall_a, 32'h4);
        chk("multi_sw", sw_a, 32'h8000_000B);
      end
    end
    chk("multi_chg_count", n, 1);

    // ---------------- async reset mid-debounce ----------------
    @(negedge clk);
    raw_a = 32'h8000_001B;
    repeat (5) step();
    chk("mid_pending_sw", sw_a, 32'h8000_000B);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_sw", sw_a, 32'h0000_00A5);
    chk("mid_rst_chg", {31'h0, chg_a}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      step();
      chk("mid_relatch_hold", sw_a, 32'h0000_00A5);
    end
    step();
    chk("mid_relatch_sw", sw_a, 32'h8000_001B);
    chk("mid_relatch_rise", rise_a, 32'h8000_001A);
    chk("mid_relatch_fall", fall_a, 32'h0000_00A4);

    // ---------------- TICK_DIV=4: tick period and glitch rejection ----------------
    found = 0;
    for (int k = 0; k < 8 && found == 0; k++) begin
      step();
      if (tick_b) found = 1;
    end
    chk("b_tick_found", found, 1);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == 5) raw_b[10] = 1'b1;
      if (k == 8) raw_b[10] = 1'b0;
      step();
      tests++;
      assert (tick_b === (k % 4 == 0)) else begin
        fails++;
        $error("FAIL b_tick_period cycle=%0d observed=%b expected=%b", k, tick_b, (k % 4 == 0));
      end
      if (chg_b || rise_b != 0 || fall_b != 0) n++;
    end
    chk("b_glitch_sw", sw_b, 32'h0);
    chk("b_glitch_pulses", n, 0);

    // ---------------- TICK_DIV=4: accepted step latency ----------------
    @(negedge clk);
    raw_b[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 30 && lat == 0; k++) begin
      step();
      if (sw_b[0]) begin
        lat = k;
        chk("b_step_rise", rise_b, 32'h1);
        chk("b_step_tick", {31'h0, tick_b}, 32'h1);
      end
    end
    tests++;
    assert (lat >= 15 && lat <= 18) else begin
      fails++;
      $error("FAIL b_step_latency observed=%0d expected=15..18", lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
